// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Holds FSM states, funct3 width codes, fault causes and the access-size helper.
package lsu_pkg;

    localparam int LSU_ADDR_W = 32;
    localparam int LSU_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        FC_NONE       = 2'd0,
        FC_MISALIGNED = 2'd1,
        FC_ILLEGAL    = 2'd2
    } fault_cause_t;

    // Returns 1 when the access of this size does not sit on its natural boundary.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic r_mis;
        case (funct3[1:0])
            2'd1:    r_mis = addr_lo[0];
            2'd2:    r_mis = (addr_lo != 2'd0);
            default: r_mis = 1'b0;
        endcase
        return r_mis;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the execute-side request, data-memory port and writeback result of the LSU.
// master = pipeline/memory environment, slave = the LSU itself.
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic              is_load;
    logic              is_store;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] store_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;

    logic              done_valid;
    logic [DATA_W-1:0] load_data;
    logic              fault;
    logic [1:0]        fault_cause;

    modport master (
        output req_valid, is_load, is_store, funct3, addr, store_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  req_ready, mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
        input  done_valid, load_data, fault, fault_cause
    );

    modport slave (
        input  req_valid, is_load, is_store, funct3, addr, store_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output req_ready, mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
        output done_valid, load_data, fault, fault_cause
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: legality/alignment check and store lane steering on the
// request side, byte/half extraction with sign or zero extension on the response side.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_is_load,
    input  logic              i_is_store,
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [2:0]        i_rsp_funct3,
    input  logic [1:0]        i_rsp_addr_lo,
    input  logic [DATA_W-1:0] i_rdata,
    output fault_cause_t      o_cause,
    output logic [3:0]        o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_load_data
);

    logic        w_illegal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Illegal takes priority over misaligned so an undefined funct3 never reports alignment.
    always_comb begin
        w_illegal = 1'b0;
        if (i_is_load == i_is_store) begin
            w_illegal = 1'b1;
        end else if (i_is_load) begin
            case (i_funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: w_illegal = 1'b0;
                default:                        w_illegal = 1'b1;
            endcase
        end else begin
            w_illegal = (i_funct3 > F3_W);
        end

        if (w_illegal) begin
            o_cause = FC_ILLEGAL;
        end else if (is_misaligned(i_funct3, i_addr_lo)) begin
            o_cause = FC_MISALIGNED;
        end else begin
            o_cause = FC_NONE;
        end
    end

    // Stores replicate the datum into every lane so the enables alone pick the target bytes.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = {DATA_W{1'b0}};
        if (i_is_store) begin
            case (i_funct3)
                F3_B: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_store_data[7:0]}};
                end
                F3_H: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_store_data[15:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_store_data;
                end
            endcase
        end else begin
            o_be    = 4'b1111;
            o_wdata = {DATA_W{1'b0}};
        end
    end

    // Response formatting uses the op latched at acceptance, not the live request fields.
    always_comb begin
        case (i_rsp_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_rsp_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_rsp_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'd0, w_half};
            F3_W:    o_load_data = i_rdata;
            default: o_load_data = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: accepts one op from execute, runs a single-outstanding
// valid/ready memory access and returns formatted load data with a one-cycle done pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    lsu_if.slave  io_bus
);

    lsu_state_t        r_state;
    logic              r_req_ready;
    logic              r_mem_req_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_done_valid;
    logic [DATA_W-1:0] r_load_data;
    logic              r_fault;
    fault_cause_t      r_fault_cause;
    logic              r_is_load;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;

    fault_cause_t      w_cause;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_load_fmt;

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_is_load     (io_bus.is_load),
        .i_is_store    (io_bus.is_store),
        .i_funct3      (io_bus.funct3),
        .i_addr_lo     (io_bus.addr[1:0]),
        .i_store_data  (io_bus.store_data),
        .i_rsp_funct3  (r_funct3),
        .i_rsp_addr_lo (r_addr_lo),
        .i_rdata       (io_bus.mem_rsp_rdata),
        .o_cause       (w_cause),
        .o_be          (w_be),
        .o_wdata       (w_wdata),
        .o_load_data   (w_load_fmt)
    );

    // Control FSM; every output is a register updated on the transition that defines it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_req_ready     <= 1'b1;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= {ADDR_W{1'b0}};
            r_mem_we        <= 1'b0;
            r_mem_be        <= 4'b0000;
            r_mem_wdata     <= {DATA_W{1'b0}};
            r_done_valid    <= 1'b0;
            r_load_data     <= {DATA_W{1'b0}};
            r_fault         <= 1'b0;
            r_fault_cause   <= FC_NONE;
            r_is_load       <= 1'b0;
            r_funct3        <= 3'd0;
            r_addr_lo       <= 2'd0;
        end else begin
            r_done_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.req_valid) begin
                        r_req_ready   <= 1'b0;
                        r_is_load     <= io_bus.is_load;
                        r_funct3      <= io_bus.funct3;
                        r_addr_lo     <= io_bus.addr[1:0];
                        r_load_data   <= {DATA_W{1'b0}};
                        r_fault_cause <= w_cause;
                        if (w_cause == FC_NONE) begin
                            r_fault         <= 1'b0;
                            r_mem_addr      <= {io_bus.addr[ADDR_W-1:2], 2'b00};
                            r_mem_we        <= io_bus.is_store;
                            r_mem_be        <= w_be;
                            r_mem_wdata     <= w_wdata;
                            r_mem_req_valid <= 1'b1;
                            r_state         <= ST_REQ;
                        end else begin
                            r_fault      <= 1'b1;
                            r_done_valid <= 1'b1;
                            r_state      <= ST_DONE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (io_bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        if (r_is_load) begin
                            r_state <= ST_WAIT_RSP;
                        end else begin
                            r_done_valid <= 1'b1;
                            r_state      <= ST_DONE;
                        end
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_WAIT_RSP: begin
                    if (io_bus.mem_rsp_valid) begin
                        r_load_data  <= w_load_fmt;
                        r_done_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_state <= ST_WAIT_RSP;
                    end
                end
                ST_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_req_ready     <= 1'b1;
                    r_mem_req_valid <= 1'b0;
                    r_state         <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.req_ready     = r_req_ready;
    assign io_bus.mem_req_valid = r_mem_req_valid;
    assign io_bus.mem_addr      = r_mem_addr;
    assign io_bus.mem_we        = r_mem_we;
    assign io_bus.mem_be        = r_mem_be;
    assign io_bus.mem_wdata     = r_mem_wdata;
    assign io_bus.done_valid    = r_done_valid;
    assign io_bus.load_data     = r_load_data;
    assign io_bus.fault         = r_fault;
    assign io_bus.fault_cause   = r_fault_cause;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly downstream of the ALU in the execute/memory path.
- Takes the ALU result as the effective address, plus rs2 data and funct3 for RV32I loads and stores.
- Drives a single-outstanding valid/ready data-memory port and returns aligned, sign/zero-extended load data to writeback.
- Stalls the pipeline until the access completes.

Parameters:
ADDR_W, 32, effective/memory address width
DATA_W, 32, data width (fixed at 32 for RV32I; other values unsupported)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  execute stage presents a memory op
req_ready  out  1  LSU can accept an op
is_load  in  1  op is a load
is_store  in  1  op is a store
funct3  in  3  RV32I width/sign field
addr  in  ADDR_W  effective address (ALU result)
store_data  in  DATA_W  rs2 value
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
mem_we  out  1  1 = write
mem_be  out  4  byte enables
mem_wdata  out  DATA_W  lane-replicated write data
mem_rsp_valid  in  1  read data valid
mem_rsp_rdata  in  DATA_W  read word
done_valid  out  1  one-cycle completion pulse
load_data  out  DATA_W  formatted load result
fault  out  1  access faulted (valid with done_valid)
fault_cause  out  2  0 none, 1 misaligned, 2 illegal funct3/op

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0 except req_ready=1; latched op cleared.
- States: IDLE, REQ, WAIT_RSP, DONE.
- req_ready = (state==IDLE).
- IDLE: on req_valid, latch addr/funct3/store_data/op.
  - If the op is legal and aligned -> REQ.
  - Otherwise -> DONE with fault set; no memory request issued.
- Illegal: is_load==is_store; load funct3 in {3,6,7}; store funct3 >= 3.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- REQ: mem_req_valid=1. mem_addr/mem_we/mem_be/mem_wdata are held stable until mem_req_ready.
  - On handshake: store -> DONE; load -> WAIT_RSP.
- WAIT_RSP: on mem_rsp_valid, capture the formatted rdata into load_data -> DONE.
- DONE: done_valid=1 for exactly one cycle, then -> IDLE. load_data and fault hold until the next acceptance.
- Minimum latency, acceptance to done_valid, with zero-wait memory:
  - Store: 2 cycles.
  - Load: 3 cycles (response arriving in the cycle after the handshake).
  - Faulting op: 1 cycle.
- Store lanes:
  - SB: be = 1<<addr[1:0], wdata = {4{store_data[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{store_data[15:0]}}.
  - SW: be = 1111.
  - Loads: mem_we=0, be=1111.
- Load extract: byte lane addr[1:0] or half lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Store results: load_data=0. Faulting ops: load_data=0.
- mem_rsp_valid outside WAIT_RSP is ignored, including stale responses after reset.
- req_valid while not IDLE is ignored. The upstream stage holds its op, since req_ready=0.
- Reset mid-operation aborts to IDLE immediately. The memory side must tolerate the dropped request.

Decomposition:
- Package lsu_pkg:
  - lsu_state_t enum.
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - fault_cause_t codes.
- Sub-module lsu_align (combinational):
  - Store byte-lane/be generation.
  - Load extract/extend.
  - Legality/misalignment checks.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, mem_req_ready=1 -> mem_addr=0x100, we=1, be=1111, wdata=0xDEADBEEF; done_valid 2 cycles after acceptance; fault=0.
- SB addr=0x103, data=0x12345678 -> mem_addr=0x100, be=1000, wdata=0x78787878.
- LB addr=0x102, rdata=0x80FF1234 -> load_data=0xFFFFFFFF. LBU same -> 0x000000FF. LH addr=0x102 -> 0xFFFF80FF. LHU addr=0x100 -> 0x00001234.
- LH addr=0x101 -> no mem_req_valid; done_valid next cycle, fault=1, cause=1. Load funct3=3 -> fault=1, cause=2.
- Load with mem_req_ready low for 3 cycles, then rsp 2 cycles after the handshake -> mem_addr/be stable while waiting; done_valid exactly once; req_ready=0 throughout.
- Assert reset during WAIT_RSP, then pulse mem_rsp_valid after release -> state IDLE, done_valid never asserted, req_ready=1.
